// File: rtl/game_clock_ctrl.sv
// Countdown game clock: BCD mm:ss with run/pause/clear/minute-add and expiry buzzer.
// All outputs are registered; tick is high while the prescaler sits at its last count.
module game_clock_ctrl #(
    parameter logic [26:0] TICK_DIV    = 27'd100000000,
    parameter logic [3:0]  PRESET_MT   = 4'd1,
    parameter logic [3:0]  PRESET_MO   = 4'd2,
    parameter logic [23:0] BUZZ_CYCLES = 24'd5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick,
    output logic       running,
    output logic       expired,
    output logic       buzzer
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t      state_q, state_d;
    logic [26:0] presc_q, presc_d;
    logic [3:0]  mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [23:0] bcnt_q, bcnt_d;
    logic        tick_q, tick_d, run_q, run_d, exp_q, exp_d, buzz_q, buzz_d;

    logic        tick_now, time_zero, last_sec, inc_nonzero;
    logic [3:0]  inc_mt, inc_mo;

    assign tick_now  = (state_q == RUN) && (presc_q == TICK_DIV - 27'd1);
    assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign last_sec  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    always_comb begin
        inc_mo = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
        inc_mt = mt_q;
        if (mo_q == 4'd9) begin
            inc_mt = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
        end
    end

    // Start from IDLE is judged on the time after any same-cycle minute add.
    assign inc_nonzero = (inc_mt != 4'd0) || (inc_mo != 4'd0) || (st_q != 4'd0) || (so_q != 4'd0);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        bcnt_d  = bcnt_q;
        buzz_d  = buzz_q;

        if (buzz_q) begin
            bcnt_d = bcnt_q - 24'd1;
            buzz_d = (bcnt_q != 24'd1);
        end

        if (clear) begin
            state_d = IDLE;
            presc_d = 27'd0;
            mt_d    = PRESET_MT;
            mo_d    = PRESET_MO;
            st_d    = 4'd0;
            so_d    = 4'd0;
            bcnt_d  = 24'd0;
            buzz_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc_min) begin
                        mt_d = inc_mt;
                        mo_d = inc_mo;
                    end
                    if (start_stop && (inc_min ? inc_nonzero : !time_zero)) begin
                        state_d = RUN;
                    end
                end
                PAUSE: begin
                    if (inc_min) begin
                        mt_d = inc_mt;
                        mo_d = inc_mo;
                    end
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick_now) begin
                        presc_d = 27'd0;
                        // A 00:00 reached by minute wrap in PAUSE expires instead of underflowing.
                        if (time_zero || last_sec) begin
                            mt_d    = 4'd0;
                            mo_d    = 4'd0;
                            st_d    = 4'd0;
                            so_d    = 4'd0;
                            state_d = EXPIRED;
                            buzz_d  = 1'b1;
                            bcnt_d  = BUZZ_CYCLES;
                        end else begin
                            so_d = (so_q == 4'd0) ? 4'd9 : so_q - 4'd1;
                            if (so_q == 4'd0) begin
                                st_d = (st_q == 4'd0) ? 4'd5 : st_q - 4'd1;
                                if (st_q == 4'd0) begin
                                    mo_d = (mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1;
                                    if (mo_q == 4'd0) begin
                                        mt_d = mt_q - 4'd1;
                                    end
                                end
                            end
                            if (start_stop) begin
                                state_d = PAUSE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 27'd1;
                        if (start_stop) begin
                            state_d = PAUSE;
                        end
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        tick_d = (state_d == RUN) && (presc_d == TICK_DIV - 27'd1);
        run_d  = (state_d == RUN);
        exp_d  = (state_d == EXPIRED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= 27'd0;
            mt_q    <= PRESET_MT;
            mo_q    <= PRESET_MO;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            bcnt_q  <= 24'd0;
            buzz_q  <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            bcnt_q  <= bcnt_d;
            buzz_q  <= buzz_d;
            tick_q  <= tick_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign tick     = tick_q;
    assign running  = run_q;
    assign expired  = exp_q;
    assign buzzer   = buzz_q;

endmodule
